// File: rtl/ones_pattern_gen.sv
// Serial ones-pattern generator: builds a WIDTH-bit word holding a
// requested number of set bits, one bit per clock, from a rotation offset.
module ones_pattern_gen #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int ROT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [CNT_W-1:0] COUNT_IN,
    input  logic [ROT_W-1:0] ROT_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic [CNT_W-1:0] COUNT_OUT,
    output logic             VALID_OUT,
    input  logic             ACK_IN,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUILD,
        S_HOLD
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_rem;
    logic [ROT_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             r_busy;

    logic [CNT_W-1:0] w_target;
    logic [ROT_W-1:0] w_ptr_nxt;

    // Requests above WIDTH saturate; the pointer wraps at the top bit.
    assign w_target  = (COUNT_IN > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : COUNT_IN;
    assign w_ptr_nxt = (r_ptr == ROT_W'(WIDTH - 1)) ? '0 : r_ptr + ROT_W'(1);

    // Control FSM with all outputs registered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_ptr   <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_rem   <= w_target;
                        r_ptr   <= ROT_IN;
                        r_data  <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_BUILD;
                    end
                end
                S_BUILD: begin
                    if (r_rem != '0) begin
                        r_data[r_ptr] <= 1'b1;
                        r_ptr         <= w_ptr_nxt;
                        r_rem         <= r_rem - CNT_W'(1);
                        r_count       <= r_count + CNT_W'(1);
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ACK_IN) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign DATA_OUT  = r_data;
    assign COUNT_OUT = r_count;
    assign VALID_OUT = r_valid;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Scoreboard bench for ones_pattern_gen: stimulus queues expected results,
// a negedge monitor compares whenever the DUT presents them.
module tb_ones_pattern_gen;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  cnt;
        int          lat;
    } exp_t;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [4:0]  COUNT_IN;
    logic [3:0]  ROT_IN;
    logic [15:0] DATA_OUT;
    logic [4:0]  COUNT_OUT;
    logic        VALID_OUT;
    logic        ACK_IN;
    logic        BUSY;

    exp_t        q_exp[$];
    logic [15:0] q_trace[$];

    int n_cmp;
    int n_fail;
    int n_neg;

    ones_pattern_gen #(
        .WIDTH(16),
        .CNT_W(5),
        .ROT_W(4)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .COUNT_IN (COUNT_IN),
        .ROT_IN   (ROT_IN),
        .DATA_OUT (DATA_OUT),
        .COUNT_OUT(COUNT_OUT),
        .VALID_OUT(VALID_OUT),
        .ACK_IN   (ACK_IN),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Monitor
    exp_t        cur;
    logic        have_cur;
    logic        prev_busy;
    logic        prev_valid;
    logic [4:0]  prev_count;
    int          start_n;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        n_neg = 0;
        have_cur = 1'b0;
        prev_busy = 1'b0;
        prev_valid = 1'b0;
        prev_count = '0;
        start_n = 0;
        forever begin
            @(negedge CLK);
            n_neg++;
            if (!RST_N) begin
                check("rst_data", 32'(DATA_OUT), 32'h0);
                check("rst_count", 32'(COUNT_OUT), 32'h0);
                check("rst_valid", 32'(VALID_OUT), 32'h0);
                check("rst_busy", 32'(BUSY), 32'h0);
                have_cur = 1'b0;
                prev_busy = 1'b0;
                prev_valid = 1'b0;
                prev_count = '0;
            end else begin
                check("invariant", 32'(COUNT_OUT), 32'($countones(DATA_OUT)));
                if (BUSY && !prev_busy) begin
                    start_n = n_neg;
                    check("start_clr", 32'(DATA_OUT), 32'h0);
                end
                if (BUSY && prev_busy && !VALID_OUT &&
                    COUNT_OUT != prev_count && q_trace.size() > 0) begin
                    check("trace", 32'(DATA_OUT), 32'(q_trace.pop_front()));
                end
                if (VALID_OUT && !prev_valid) begin
                    if (q_exp.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_valid: data %0h", DATA_OUT);
                    end else begin
                        cur = q_exp.pop_front();
                        have_cur = 1'b1;
                        check("latency", 32'(n_neg - start_n), 32'(cur.lat));
                    end
                end
                if (VALID_OUT && have_cur) begin
                    check("hold_data", 32'(DATA_OUT), 32'(cur.data));
                    check("hold_count", 32'(COUNT_OUT), 32'(cur.cnt));
                    check("hold_busy", 32'(BUSY), 32'h1);
                end
                if (!VALID_OUT && !BUSY && have_cur) begin
                    check("idle_data", 32'(DATA_OUT), 32'(cur.data));
                    check("idle_count", 32'(COUNT_OUT), 32'(cur.cnt));
                end
                prev_busy = BUSY;
                prev_valid = VALID_OUT;
                prev_count = COUNT_OUT;
            end
        end
    end

    // One request: queue its expectation, wait for VALID, then acknowledge.
    task automatic req(input logic [4:0] cnt, input logic [3:0] rot,
                       input logic [15:0] edata, input logic [4:0] ecnt,
                       input int hold, input bit start_in_hold,
                       input bit start_with_ack);
        exp_t e;
        int k;
        e.data = edata;
        e.cnt = ecnt;
        e.lat = int'(ecnt) + 1;
        q_exp.push_back(e);
        @(negedge CLK);
        START = 1'b1;
        COUNT_IN = cnt;
        ROT_IN = rot;
        @(negedge CLK);
        START = 1'b0;
        k = 0;
        while (!VALID_OUT && k < 40) begin
            @(negedge CLK);
            k++;
        end
        if (!VALID_OUT) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: valid %0b want 1", VALID_OUT);
        end
        for (int i = 0; i < hold; i++) begin
            START = start_in_hold && (i == 2);
            COUNT_IN = 5'd1;
            ROT_IN = 4'd0;
            @(negedge CLK);
        end
        START = start_with_ack;
        ACK_IN = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        ACK_IN = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        RST_N = 1'b0;
        START = 1'b0;
        COUNT_IN = '0;
        ROT_IN = '0;
        ACK_IN = 1'b0;
        repeat (3) @(negedge CLK);
        #1 RST_N = 1'b1;

        req(5'd15, 4'd0, 16'h7FFF, 5'd15, 1, 1'b0, 1'b0);

        q_trace.push_back(16'h4000);
        q_trace.push_back(16'hC000);
        q_trace.push_back(16'hC001);
        q_trace.push_back(16'hC003);
        req(5'd4, 4'd14, 16'hC003, 5'd4, 1, 1'b0, 1'b0);

        req(5'd0, 4'd5, 16'h0000, 5'd0, 1, 1'b0, 1'b0);
        req(5'd16, 4'd7, 16'hFFFF, 5'd16, 1, 1'b0, 1'b0);
        req(5'd20, 4'd3, 16'hFFFF, 5'd16, 5, 1'b1, 1'b1);

        // Reset in the middle of a build, three bits in.
        @(negedge CLK);
        START = 1'b1;
        COUNT_IN = 5'd10;
        ROT_IN = 4'd0;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        #1 RST_N = 1'b1;

        req(5'd2, 4'd0, 16'h0003, 5'd2, 1, 1'b0, 1'b0);

        check("q_exp_empty", 32'(q_exp.size()), 32'h0);
        check("q_trace_empty", 32'(q_trace.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
